gp_cmd_dispatch: RTL and testbench

Parametrised graphics command processor. It parses a 32-bit command-word stream (already unpacked from DRAM by the command fetch FIFO) and dispatches line commands round-robin across NUM_LE line engines and fill commands to the frame filler. It sits between the command fetch FIFO and the engine bank, and raises GP_interrupt to the processor on STOP. Compared with the single-engine processor, it adds multi-engine dispatch, a restart flush, and registered, handshake-clean issue.

---
 rtl/gp_cmd_dispatch.sv | 166 ++++++++++++++++
 tb/tb_gp_cmd_dispatch.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_cmd_dispatch.sv
// Graphics command processor: parses the command-word stream, spreads LINE work round-robin over the line
// engines and hands FILL work to the frame filler. Define GP_ERR_EN to halt with an interrupt on unknown opcodes.
module gp_cmd_dispatch #(
    parameter int NUM_LE  = 2,
    parameter int COORD_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            cmd_word,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    output logic                   cmd_flush,
    input  logic                   GP_valid,
    input  logic [31:0]            GP_FRAME,
    output logic                   GP_interrupt,
    input  logic [NUM_LE-1:0]      LE_ready,
    output logic [31:0]            LE_color,
    output logic [2*COORD_W-1:0]   LE_point,
    output logic [NUM_LE-1:0]      LE_color_valid,
    output logic [NUM_LE-1:0]      LE_point0_valid,
    output logic [NUM_LE-1:0]      LE_point1_valid,
    output logic [NUM_LE-1:0]      LE_trigger,
    output logic [31:0]            LE_frame,
    output logic [31:0]            FF_frame,
    input  logic                   FF_ready,
    output logic                   FF_valid,
    output logic [23:0]            FF_color
);

    localparam int SEL_W = (NUM_LE > 1) ? $clog2(NUM_LE) : 1;
    localparam logic [7:0] OP_STOP = 8'h00;
    localparam logic [7:0] OP_LINE = 8'h01;
    localparam logic [7:0] OP_FILL = 8'h02;

    typedef enum logic [3:0] {
        IDLE, CMD, P0, P1, LE_SEL, ISSUE_C, ISSUE_0, ISSUE_1, FF_ISSUE, HALT
    } state_t;

    state_t               state, state_nxt;
    logic [SEL_W-1:0]     rr, sel, sel_nxt, pick_idx;
    logic                 pick_found;
    logic [NUM_LE-1:0]    rot, sel_oh;
    logic [23:0]          color;
    logic [2*COORD_W-1:0] p0, p1, pt_word;
    logic [31:0]          frame;
    logic                 accept;
    logic                 unused_word_bits;

    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_LE) s = s - NUM_LE;
        return SEL_W'(s);
    endfunction

    assign accept           = cmd_valid && cmd_ready;
    assign pt_word          = {cmd_word[16+COORD_W-1:16], cmd_word[COORD_W-1:0]};
    assign unused_word_bits = ^cmd_word;
    assign LE_frame         = frame;
    assign FF_frame         = frame;

    // Ready vector rotated so bit 0 is the engine at the round-robin pointer.
    assign rot = NUM_LE'({LE_ready, LE_ready} >> rr);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_LE - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(rr, i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        if (GP_valid) begin
            state_nxt = CMD;
        end else begin
            case (state)
                CMD: begin
                    if (accept) begin
                        case (cmd_word[31:24])
                            OP_STOP: state_nxt = HALT;
                            OP_LINE: state_nxt = P0;
                            OP_FILL: state_nxt = FF_ISSUE;
`ifdef GP_ERR_EN
                            default: state_nxt = HALT;
`else
                            default: state_nxt = CMD;
`endif
                        endcase
                    end
                end
                P0:       if (accept) state_nxt = P1;
                P1:       if (accept) state_nxt = LE_SEL;
                LE_SEL: begin
                    if (pick_found) begin
                        sel_nxt   = pick_idx;
                        state_nxt = ISSUE_C;
                    end
                end
                ISSUE_C:  state_nxt = ISSUE_0;
                ISSUE_0:  state_nxt = ISSUE_1;
                ISSUE_1:  state_nxt = CMD;
                FF_ISSUE: if (FF_ready) state_nxt = CMD;
                default:  state_nxt = state;
            endcase
        end
    end

    assign sel_oh = NUM_LE'(1) << sel_nxt;

    // Outputs are registered from the next state so every strobe is flop-driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr              <= '0;
            sel             <= '0;
            frame           <= '0;
            cmd_ready       <= 1'b0;
            cmd_flush       <= 1'b0;
            GP_interrupt    <= 1'b0;
            LE_color_valid  <= '0;
            LE_point0_valid <= '0;
            LE_point1_valid <= '0;
            LE_trigger      <= '0;
            LE_color        <= '0;
            LE_point        <= '0;
            FF_valid        <= 1'b0;
            FF_color        <= '0;
        end else begin
            state        <= state_nxt;
            sel          <= sel_nxt;
            cmd_flush    <= GP_valid;
            cmd_ready    <= (state_nxt == CMD) || (state_nxt == P0) || (state_nxt == P1);
            GP_interrupt <= (state_nxt == HALT);
            FF_valid     <= (state_nxt == FF_ISSUE);
            LE_color_valid  <= (state_nxt == ISSUE_C) ? sel_oh : '0;
            LE_point0_valid <= (state_nxt == ISSUE_0) ? sel_oh : '0;
            LE_point1_valid <= (state_nxt == ISSUE_1) ? sel_oh : '0;
            LE_trigger      <= (state_nxt == ISSUE_1) ? sel_oh : '0;
            if (GP_valid) frame <= GP_FRAME;
            if (!GP_valid && state == ISSUE_1) rr <= wrap_add(sel, 1);
            if (state_nxt == ISSUE_C) LE_color <= {8'h00, color};
            if (state_nxt == ISSUE_0) LE_point <= p0;
            if (state_nxt == ISSUE_1) LE_point <= p1;
            if (state == CMD && state_nxt == FF_ISSUE) FF_color <= cmd_word[23:0];
        end
    end

    // Command payload capture; only meaningful once the matching state is reached.
    always_ff @(posedge clk) begin
        if (accept && !GP_valid) begin
            case (state)
                CMD:     color <= cmd_word[23:0];
                P0:      p0    <= pt_word;
                P1:      p1    <= pt_word;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gp_cmd_dispatch.sv
// Scoreboard bench for gp_cmd_dispatch: directed scenarios plus randomized command mix vs. a dispatch model.
module tb_gp_cmd_dispatch;
    localparam int N  = 2;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   cmd_word = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready, cmd_flush;
    logic          GP_valid = 1'b0;
    logic [31:0]   GP_FRAME = '0;
    logic          GP_interrupt;
    logic [N-1:0]  LE_ready = '0;
    logic [31:0]   LE_color;
    logic [2*CW-1:0] LE_point;
    logic [N-1:0]  LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger;
    logic [31:0]   LE_frame, FF_frame;
    logic          FF_ready = 1'b0;
    logic          FF_valid;
    logic [23:0]   FF_color;

    gp_cmd_dispatch #(.NUM_LE(N), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_word(cmd_word), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_flush(cmd_flush), .GP_valid(GP_valid), .GP_FRAME(GP_FRAME), .GP_interrupt(GP_interrupt),
        .LE_ready(LE_ready), .LE_color(LE_color), .LE_point(LE_point), .LE_color_valid(LE_color_valid),
        .LE_point0_valid(LE_point0_valid), .LE_point1_valid(LE_point1_valid), .LE_trigger(LE_trigger),
        .LE_frame(LE_frame), .FF_frame(FF_frame), .FF_ready(FF_ready), .FF_valid(FF_valid),
        .FF_color(FF_color)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 color strobe, 1 point0, 2 point1+trigger, 3 fill handshake, 4 interrupt, 5 restart
    typedef struct {
        int          kind;
        logic [N-1:0] oh;
        logic [23:0] color;
        logic [2*CW-1:0] pt;
        logic [31:0] frame;
        int          len;
        int          ecyc;
    } ev_t;

    ev_t         q[$];
    int          checks = 0;
    int          errors = 0;
    int          rr_m = 0;
    logic [31:0] frame_m = '0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_ev(input string what, output bit ok, output ev_t e);
        e = '{default: 0};
        if (q.size() == 0) begin
            checks++;
            errors++;
            ok = 1'b0;
            $display("FAIL unexpected_%s got event expected none (cycle %0d)", what, cyc);
        end else begin
            ok = 1'b1;
            e  = q.pop_front();
        end
    endtask

    // Monitor: pops one expectation per observed DUT event.
    int           last_cyc = 0;
    int           ff_len = 0;
    logic         prev_int = 1'b0;
    logic [4*N-1:0] stb, exp_stb;
    ev_t          me;
    bit           mok, lem;
    logic [2*CW-1:0] act_pt, exp_pt;
    int           act_gap, exp_gap, act_lat;

    always @(negedge clk) begin
        if (rst) begin
            ff_len   = 0;
            prev_int = 1'b0;
        end else begin
            stb = {LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger};
            if (stb != '0) begin
                pop_ev("le_strobe", mok, me);
                if (mok) begin
                    case (me.kind)
                        0:       exp_stb = {me.oh, {(3*N){1'b0}}};
                        1:       exp_stb = {{N{1'b0}}, me.oh, {(2*N){1'b0}}};
                        2:       exp_stb = {{(2*N){1'b0}}, me.oh, me.oh};
                        default: exp_stb = '0;
                    endcase
                    lem     = (me.kind == 0);
                    act_pt  = lem ? '0 : LE_point;
                    exp_pt  = lem ? '0 : me.pt;
                    act_gap = lem ? 0 : cyc - last_cyc;
                    exp_gap = lem ? 0 : 1;
                    act_lat = (lem && me.ecyc >= 0) ? cyc : me.ecyc;
                    check("le_issue", {stb, LE_color, act_pt, LE_frame, act_gap, act_lat},
                          {exp_stb, 8'h00, me.color, exp_pt, me.frame, exp_gap, me.ecyc});
                end
                last_cyc = cyc;
            end
            if (FF_valid) ff_len++;
            if (FF_valid && FF_ready) begin
                pop_ev("ff_valid", mok, me);
                if (mok) check("ff_issue", {me.kind == 3, FF_color, FF_frame, ff_len},
                               {1'b1, me.color, me.frame, me.len});
                ff_len = 0;
            end
            if (GP_interrupt && !prev_int) begin
                pop_ev("interrupt", mok, me);
                if (mok) check("interrupt", {me.kind == 4, GP_interrupt, cmd_ready}, 3'b110);
            end
            prev_int = GP_interrupt;
            if (cmd_flush) begin
                pop_ev("flush", mok, me);
                if (mok) check("restart", {me.kind == 5, GP_interrupt, cmd_ready, LE_frame, FF_frame, stb, FF_valid},
                               {1'b1, 1'b0, 1'b1, me.frame, me.frame, {(4*N){1'b0}}, 1'b0});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string what);
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending %0d expected 0", what, q.size());
            q.delete();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps, output int acc);
        int n = 0;
        cmd_word  = w;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout got cmd_ready 0 expected 1 word %h", w);
        end
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
    endtask

    function automatic logic [31:0] pt_word(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [31:0] w;
        w = $urandom;
        w[16+CW-1:16] = x;
        w[CW-1:0] = y;
        return w;
    endfunction

    task automatic restart(input logic [31:0] f);
        ev_t e = '{default: 0};
        e.kind  = 5;
        e.frame = f;
        frame_m = f;
        q.push_back(e);
        GP_FRAME = f;
        GP_valid = 1'b1;
        tick();
        GP_valid = 1'b0;
        GP_FRAME = $urandom;
        drain("restart");
    endtask

    // Issue one LINE and push its three expected strobes; engine chosen round-robin over v.
    task automatic line_start(input logic [23:0] color, input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                              input logic [CW-1:0] x1, input logic [CW-1:0] y1, input logic [N-1:0] v,
                              input bit directed);
        ev_t e = '{default: 0};
        int  k = -1;
        int  acc, dummy;
        for (int i = 0; i < N; i++) begin
            if (k < 0 && v[(rr_m + i) % N]) k = (rr_m + i) % N;
        end
        rr_m     = (k + 1) % N;
        LE_ready = directed ? v : '0;
        send_word({8'h01, color}, !directed, acc);
        e.oh = N'(1) << k;
        e.color = color;
        e.frame = frame_m;
        e.kind = 0;
        e.ecyc = directed ? acc + 4 : -1;
        q.push_back(e);
        e.ecyc = -1;
        e.kind = 1;
        e.pt = {x0, y0};
        q.push_back(e);
        e.kind = 2;
        e.pt = {x1, y1};
        q.push_back(e);
        send_word(pt_word(x0, y0), !directed, dummy);
        send_word(pt_word(x1, y1), !directed, dummy);
        if (!directed) begin
            repeat ($urandom_range(0, 2)) tick();
            LE_ready = v;
        end
    endtask

    task automatic do_line(input logic [23:0] color, input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                           input logic [CW-1:0] x1, input logic [CW-1:0] y1, input logic [N-1:0] v,
                           input bit directed);
        line_start(color, x0, y0, x1, y1, v, directed);
        tick();
        LE_ready = N'($urandom);
        drain("line");
    endtask

    task automatic do_fill(input logic [23:0] color, input int r);
        ev_t e = '{default: 0};
        int  acc;
        e.kind  = 3;
        e.color = color;
        e.frame = frame_m;
        e.len   = r + 1;
        FF_ready = 1'b0;
        q.push_back(e);
        send_word({8'h02, color}, 1'b0, acc);
        repeat (r) tick();
        FF_ready = 1'b1;
        tick();
        FF_ready = 1'b0;
        drain("fill");
    endtask

    task automatic do_stop();
        ev_t e = '{default: 0};
        int  acc;
        e.kind = 4;
        q.push_back(e);
        send_word({8'h00, 24'($urandom)}, 1'b0, acc);
        drain("stop");
        repeat (3) tick();
        check("halt_hold", {GP_interrupt, cmd_ready}, 2'b10);
        restart($urandom);
    endtask

    task automatic do_unknown(input logic [7:0] op);
        int acc;
`ifdef GP_ERR_EN
        ev_t e = '{default: 0};
        e.kind = 4;
        q.push_back(e);
`endif
        send_word({op, 24'($urandom)}, 1'b0, acc);
        drain("unknown");
`ifdef GP_ERR_EN
        restart($urandom);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {cmd_ready, cmd_flush, GP_interrupt, LE_color, LE_point, LE_color_valid,
                                LE_point0_valid, LE_point1_valid, LE_trigger, LE_frame, FF_valid, FF_color}, '0);
        rst = 1'b0;
        tick();
        check("idle_not_ready", {cmd_ready, GP_interrupt}, 2'b00);
        restart(32'h10400000);

        do_line(24'h00FF00, 10'd5, 10'd7, 10'd100, 10'd200, 2'b11, 1'b1);
        do_line(24'h00FF00, 10'd5, 10'd7, 10'd100, 10'd200, 2'b11, 1'b1);
        do_line(24'h123456, 10'd1, 10'd2, 10'd3, 10'd4, 2'b10, 1'b1);
        do_line(24'hABCDEF, 10'd1023, 10'd0, 10'd0, 10'd1023, 2'b11, 1'b1);
        do_fill(24'hFF0000, 3);
        do_fill(24'h0000FF, 0);
        do_stop();
        do_unknown(8'h7F);
        do_fill(24'h00AA55, 1);

        // Asynchronous reset in the middle of an issue, then confirm rr restarted at 0.
        do_line(24'h111111, 10'd9, 10'd9, 10'd9, 10'd9, 2'b01, 1'b1);
        line_start(24'h222222, 10'd8, 10'd8, 10'd8, 10'd8, 2'b11, 1'b1);
        begin
            int n = 0;
            while (LE_point0_valid == '0 && n < 20) begin
                tick();
                n++;
            end
            check("reach_issue0", {LE_point0_valid}, 2'b10);
        end
        rst = 1'b1;
        #1;
        check("reset_mid_issue", {cmd_ready, cmd_flush, GP_interrupt, LE_color, LE_point, LE_color_valid,
                                  LE_point0_valid, LE_point1_valid, LE_trigger, LE_frame, FF_valid, FF_color}, '0);
        q.delete();
        rr_m = 0;
        tick();
        rst = 1'b0;
        LE_ready = '0;
        tick();
        restart(32'h20000000);
        do_line(24'h333333, 10'd7, 10'd6, 10'd5, 10'd4, 2'b11, 1'b1);

        for (int it = 0; it < 120; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55)
                do_line(24'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom),
                        N'($urandom_range(1, (1 << N) - 1)), 1'b0);
            else if (r < 80) do_fill(24'($urandom), $urandom_range(0, 3));
            else if (r < 88) do_unknown(8'($urandom_range(3, 255)));
            else if (r < 94) do_stop();
            else restart($urandom);
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
